spi_host_ctrl: RTL

- SPI mode-0 initiator that drives the accelerator's SPI target pins (spi_clk, cs, mosi, miso) from the sys_clk domain.
- Used by the bench harness and by the future on-chip host-side bridge: it loads matrix operand bytes and reads back 18-bit result words.
- Command-driven: each accepted command shifts out one byte (write) or shifts in one RX_BITS word (read).
- cs stays asserted across commands until one is flagged last.

---
 rtl/spi_host_pkg.sv | 26 ++
 rtl/spi_clk_div.sv | 50 +++++
 rtl/spi_host_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_host_pkg.sv
// Shared definitions for the SPI mode-0 host controller.
// Contents: controller state encoding, command-direction codes,
// the default read-word width and a small constant-sizing helper.
package spi_host_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        SHIFT   = 3'd2,
        HOLD    = 3'd3,
        RELEASE = 3'd4,
        GAP     = 3'd5
    } state_t;

    localparam logic CMD_WRITE = 1'b1;
    localparam logic CMD_READ  = 1'b0;

    // Matches the matmult result word width.
    localparam int DEFAULT_RX_BITS = 18;

    // Larger of two integers, used to size counters at elaboration time.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period divider for the SPI serial clock.
// Ports:
//   sys_clk        system clock, rising edge
//   rst            asynchronous reset, active-low
//   en             run the divider; while low the phase is held at the
//                  start of a low half, so every rise of en restarts it
//   rise_stb       one-cycle strobe: the edge ending a low half
//   fall_stb       one-cycle strobe: the edge ending a high half
//   spi_clk_level  registered serial clock level (idles low)
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic en,
    output logic rise_stb,
    output logic fall_stb,
    output logic spi_clk_level
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             half_end_s;

    // The strobes mark the edge on which the level toggles.
    assign half_end_s    = en && (cnt_r == CNT_LAST);
    assign rise_stb      = half_end_s && !level_r;
    assign fall_stb      = half_end_s && level_r;
    assign spi_clk_level = level_r;

    // Half-period counter and serial clock level.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            cnt_r   <= '0;
            level_r <= 1'b0;
        end else if (!en) begin
            cnt_r   <= '0;
            level_r <= 1'b0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r   <= '0;
            level_r <= !level_r;
        end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_host_ctrl.sv
// SPI mode-0 initiator driven by byte-write / word-read commands.
// Ports:
//   sys_clk, rst             clock (rising edge) and async active-low reset
//   cmd_valid/cmd_ready      command handshake, accepted when both high
//   cmd_write, cmd_data      1 = send cmd_data byte, 0 = read RX_BITS word
//   cmd_last                 release cs after this command
//   rsp_valid, rsp_data      one-cycle pulse with the received word
//   busy                     high from cs assertion until the gap expires
//   spi_clk, cs, mosi, miso  SPI target pins (cs active-low)
module spi_host_ctrl
    import spi_host_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int RX_BITS = DEFAULT_RX_BITS,
    parameter int CS_GAP  = 4
) (
    input  logic               sys_clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [7:0]         cmd_data,
    input  logic               cmd_last,
    output logic               rsp_valid,
    output logic [RX_BITS-1:0] rsp_data,
    output logic               busy,
    output logic               spi_clk,
    output logic               cs,
    output logic               mosi,
    input  logic               miso
);

    localparam int BIT_W  = $clog2(max_int(8, RX_BITS)) + 1;
    localparam int WAIT_W = $clog2(max_int(CLK_DIV, CS_GAP)) + 1;

    localparam logic [WAIT_W-1:0] DIV_LAST = WAIT_W'(CLK_DIV - 1);
    localparam logic [WAIT_W-1:0] GAP_LAST = WAIT_W'(CS_GAP - 1);
    localparam logic [BIT_W-1:0]  WR_BITS  = BIT_W'(8);
    localparam logic [BIT_W-1:0]  RD_BITS  = BIT_W'(RX_BITS);

    state_t             state_r;
    state_t             state_s;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic [BIT_W-1:0]   bit_cnt_r;
    logic [6:0]         tx_r;
    logic [RX_BITS-1:0] rx_r;
    logic               write_r;
    logic               last_r;

    logic               cs_r;
    logic               mosi_r;
    logic               busy_r;
    logic               cmd_ready_r;
    logic               rsp_valid_r;
    logic [RX_BITS-1:0] rsp_data_r;

    logic               accept_s;
    logic               shift_done_s;
    logic               cs_low_s;
    logic               div_en_s;
    logic               rise_stb_s;
    logic               fall_stb_s;
    logic               spi_clk_s;

    // The divider runs only while bits are moving; leaving SHIFT parks it
    // at the start of a low half for the next command.
    assign div_en_s = (state_r == SHIFT);

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .en            (div_en_s),
        .rise_stb      (rise_stb_s),
        .fall_stb      (fall_stb_s),
        .spi_clk_level (spi_clk_s)
    );

    // Next-state decode and command/frame events.
    always_comb begin
        state_s      = state_r;
        accept_s     = 1'b0;
        shift_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (cmd_valid && cmd_ready_r) begin
                    accept_s = 1'b1;
                    state_s  = SETUP;
                end else begin
                    state_s  = IDLE;
                end
            end
            SETUP: begin
                if (wait_cnt_r == DIV_LAST) begin
                    state_s = SHIFT;
                end else begin
                    state_s = SETUP;
                end
            end
            SHIFT: begin
                // Frame ends on the fall closing the final high half.
                if (fall_stb_s && (bit_cnt_r == BIT_W'(1))) begin
                    shift_done_s = 1'b1;
                    state_s      = last_r ? RELEASE : HOLD;
                end else begin
                    state_s      = SHIFT;
                end
            end
            HOLD: begin
                // cs is already low, so the next command skips SETUP.
                if (cmd_valid && cmd_ready_r) begin
                    accept_s = 1'b1;
                    state_s  = SHIFT;
                end else begin
                    state_s  = HOLD;
                end
            end
            RELEASE: begin
                if (wait_cnt_r == DIV_LAST) begin
                    state_s = GAP;
                end else begin
                    state_s = RELEASE;
                end
            end
            GAP: begin
                if (wait_cnt_r == GAP_LAST) begin
                    state_s = IDLE;
                end else begin
                    state_s = GAP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        cs_low_s = (state_s == SETUP) || (state_s == SHIFT) ||
                   (state_s == HOLD)  || (state_s == RELEASE);
    end

    // State register and the per-state dwell counter (cleared on every change).
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            wait_cnt_r <= '0;
        end else begin
            state_r <= state_s;
            if (state_s != state_r) begin
                wait_cnt_r <= '0;
            end else begin
                wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
            end
        end
    end

    // Command capture, bit counter and the TX/RX shift registers.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            write_r   <= CMD_READ;
            last_r    <= 1'b0;
            tx_r      <= '0;
            rx_r      <= '0;
            bit_cnt_r <= '0;
        end else if (accept_s) begin
            write_r   <= cmd_write;
            last_r    <= cmd_last;
            tx_r      <= cmd_data[6:0];
            rx_r      <= '0;
            bit_cnt_r <= (cmd_write == CMD_WRITE) ? WR_BITS : RD_BITS;
        end else if (rise_stb_s) begin
            // miso is captured on the same edge that raises spi_clk.
            rx_r <= {rx_r[RX_BITS-2:0], miso};
        end else if (fall_stb_s) begin
            tx_r      <= {tx_r[5:0], 1'b0};
            bit_cnt_r <= bit_cnt_r - BIT_W'(1);
        end
    end

    // Registered pin and status outputs.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            cs_r        <= 1'b1;
            mosi_r      <= 1'b0;
            busy_r      <= 1'b0;
            cmd_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= '0;
        end else begin
            cs_r        <= !cs_low_s;
            busy_r      <= (state_s != IDLE);
            cmd_ready_r <= (state_s == IDLE) || (state_s == HOLD);
            rsp_valid_r <= shift_done_s && (write_r == CMD_READ);
            if (shift_done_s && (write_r == CMD_READ)) begin
                rsp_data_r <= rx_r;
            end
            // The MSB is presented at acceptance so it is stable before the
            // first rise; later bits change on each fall. Reads keep mosi low.
            if (accept_s) begin
                mosi_r <= (cmd_write == CMD_WRITE) ? cmd_data[7] : 1'b0;
            end else if (shift_done_s) begin
                mosi_r <= 1'b0;
            end else if (fall_stb_s && (write_r == CMD_WRITE)) begin
                mosi_r <= tx_r[6];
            end
        end
    end

    assign cs        = cs_r;
    assign spi_clk   = spi_clk_s;
    assign mosi      = mosi_r;
    assign busy      = busy_r;
    assign cmd_ready = cmd_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;

endmodule
